// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble/flush handling.
// Define ID_EX_FORWARDING_EN to forward MEM/WB results into the EX operands.
// Without it, the stage stalls on any EX/MEM producer instead.
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [3:0]        id_exe_cmd,
  input  logic [DATA_W-1:0] id_val1,
  input  logic [DATA_W-1:0] id_val2,
  input  logic [DATA_W-1:0] id_st_val,
  input  logic [4:0]        id_src1,
  input  logic [4:0]        id_src2,
  input  logic              id_src2_is_reg,
  input  logic [4:0]        id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_rd,
  input  logic              id_mem_wr,
  input  logic              flush,
  input  logic [4:0]        mem_dest,
  input  logic              mem_wb_en,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [4:0]        wb_dest,
  input  logic              wb_wb_en,
  input  logic [DATA_W-1:0] wb_result,
  output logic              stall,
  output logic              exe_valid,
  output logic [3:0]        exe_cmd,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2,
  output logic [DATA_W-1:0] st_val,
  output logic [4:0]        exe_dest,
  output logic              exe_wb_en,
  output logic              exe_mem_rd,
  output logic              exe_mem_wr,
  output logic [15:0]       stall_cnt
);

  localparam logic [3:0] CMD_NOP = 4'd15;

  logic              exe_valid_q, exe_valid_d;
  logic [3:0]        exe_cmd_q, exe_cmd_d;
  logic [DATA_W-1:0] val1_q, val1_d;
  logic [DATA_W-1:0] val2_q, val2_d;
  logic [DATA_W-1:0] st_val_q, st_val_d;
  logic [4:0]        exe_dest_q, exe_dest_d;
  logic              exe_wb_en_q, exe_wb_en_d;
  logic              exe_mem_rd_q, exe_mem_rd_d;
  logic              exe_mem_wr_q, exe_mem_wr_d;
  logic [4:0]        exe_src1_q, exe_src1_d;
  logic [4:0]        exe_src2_q, exe_src2_d;
  logic              exe_src2_is_reg_q, exe_src2_is_reg_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic src2_used;
  logic load_use;
  logic dep_stall;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Register 0 is hardwired zero, so it can never be a real dependence.
  function automatic logic src_hit(input logic [4:0] dest, input logic [4:0] s1,
                                   input logic [4:0] s2, input logic use2);
    return (dest != 5'd0) && ((s1 == dest) || (use2 && (s2 == dest)));
  endfunction

  assign src2_used = id_src2_is_reg | id_mem_wr;
  assign load_use  = exe_valid_q & exe_mem_rd_q & id_valid &
                     src_hit(exe_dest_q, id_src1, id_src2, src2_used);

`ifdef ID_EX_FORWARDING_EN
  function automatic logic [DATA_W-1:0] fwd(input logic [4:0] src, input logic [DATA_W-1:0] raw,
                                            input logic mwe, input logic [4:0] md,
                                            input logic [DATA_W-1:0] mr, input logic wwe,
                                            input logic [4:0] wd, input logic [DATA_W-1:0] wr);
    if (src == 5'd0)           return raw;
    else if (mwe && md == src) return mr;
    else if (wwe && wd == src) return wr;
    else                       return raw;
  endfunction

  assign dep_stall = 1'b0;
  assign val1   = fwd(exe_src1_q, val1_q, mem_wb_en, mem_dest, mem_result,
                      wb_wb_en, wb_dest, wb_result);
  assign val2   = exe_src2_is_reg_q ? fwd(exe_src2_q, val2_q, mem_wb_en, mem_dest, mem_result,
                                          wb_wb_en, wb_dest, wb_result) : val2_q;
  assign st_val = exe_mem_wr_q ? fwd(exe_src2_q, st_val_q, mem_wb_en, mem_dest, mem_result,
                                     wb_wb_en, wb_dest, wb_result) : st_val_q;
`else
  logic unused_fwd;
  // Without forwarding, any in-flight producer ahead of WB forces the consumer to wait.
  assign dep_stall = id_valid &
                     ((exe_wb_en_q & src_hit(exe_dest_q, id_src1, id_src2, src2_used)) |
                      (mem_wb_en & src_hit(mem_dest, id_src1, id_src2, src2_used)));
  assign val1       = val1_q;
  assign val2       = val2_q;
  assign st_val     = st_val_q;
  assign unused_fwd = ^{mem_result, wb_result, wb_dest, wb_wb_en,
                        exe_src1_q, exe_src2_q, exe_src2_is_reg_q};
`endif

  assign stall = ~rst & ~flush & (load_use | dep_stall);

  always_comb begin
    exe_valid_d       = 1'b0;
    exe_cmd_d         = CMD_NOP;
    val1_d            = '0;
    val2_d            = '0;
    st_val_d          = '0;
    exe_dest_d        = 5'd0;
    exe_wb_en_d       = 1'b0;
    exe_mem_rd_d      = 1'b0;
    exe_mem_wr_d      = 1'b0;
    exe_src1_d        = 5'd0;
    exe_src2_d        = 5'd0;
    exe_src2_is_reg_d = 1'b0;
    stall_cnt_d       = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    if (!stall && !flush && id_valid) begin
      exe_valid_d       = 1'b1;
      exe_cmd_d         = id_exe_cmd;
      val1_d            = id_val1;
      val2_d            = id_val2;
      st_val_d          = id_st_val;
      exe_dest_d        = id_dest;
      exe_wb_en_d       = id_wb_en;
      exe_mem_rd_d      = id_mem_rd;
      exe_mem_wr_d      = id_mem_wr;
      exe_src1_d        = id_src1;
      exe_src2_d        = id_src2;
      exe_src2_is_reg_d = id_src2_is_reg;
    end
  end

  // ID -> EX boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_valid_q       <= 1'b0;
      exe_cmd_q         <= CMD_NOP;
      val1_q            <= '0;
      val2_q            <= '0;
      st_val_q          <= '0;
      exe_dest_q        <= 5'd0;
      exe_wb_en_q       <= 1'b0;
      exe_mem_rd_q      <= 1'b0;
      exe_mem_wr_q      <= 1'b0;
      exe_src1_q        <= 5'd0;
      exe_src2_q        <= 5'd0;
      exe_src2_is_reg_q <= 1'b0;
      stall_cnt_q       <= 16'd0;
    end else begin
      exe_valid_q       <= exe_valid_d;
      exe_cmd_q         <= exe_cmd_d;
      val1_q            <= val1_d;
      val2_q            <= val2_d;
      st_val_q          <= st_val_d;
      exe_dest_q        <= exe_dest_d;
      exe_wb_en_q       <= exe_wb_en_d;
      exe_mem_rd_q      <= exe_mem_rd_d;
      exe_mem_wr_q      <= exe_mem_wr_d;
      exe_src1_q        <= exe_src1_d;
      exe_src2_q        <= exe_src2_d;
      exe_src2_is_reg_q <= exe_src2_is_reg_d;
      stall_cnt_q       <= stall_cnt_d;
    end
  end

  assign exe_valid  = exe_valid_q;
  assign exe_cmd    = exe_cmd_q;
  assign exe_dest   = exe_dest_q;
  assign exe_wb_en  = exe_wb_en_q;
  assign exe_mem_rd = exe_mem_rd_q;
  assign exe_mem_wr = exe_mem_wr_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic
// compared against an instruction-level model of the EX slot.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_exe_cmd;
  logic [31:0] id_val1, id_val2, id_st_val;
  logic [4:0]  id_src1, id_src2, id_dest;
  logic        id_src2_is_reg, id_wb_en, id_mem_rd, id_mem_wr, flush;
  logic [4:0]  mem_dest, wb_dest;
  logic        mem_wb_en, wb_wb_en;
  logic [31:0] mem_result, wb_result;
  logic        stall, exe_valid, exe_wb_en, exe_mem_rd, exe_mem_wr;
  logic [3:0]  exe_cmd;
  logic [31:0] val1, val2, st_val;
  logic [4:0]  exe_dest;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_exe_cmd(id_exe_cmd),
    .id_val1(id_val1), .id_val2(id_val2), .id_st_val(id_st_val),
    .id_src1(id_src1), .id_src2(id_src2), .id_src2_is_reg(id_src2_is_reg),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
    .flush(flush), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_result(mem_result),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .wb_result(wb_result),
    .stall(stall), .exe_valid(exe_valid), .exe_cmd(exe_cmd), .val1(val1), .val2(val2),
    .st_val(st_val), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_rd(exe_mem_rd),
    .exe_mem_wr(exe_mem_wr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently occupying EX.
  typedef struct packed {
    logic        valid;
    logic [3:0]  cmd;
    logic [31:0] v1, v2, st;
    logic [4:0]  dest, s1, s2;
    logic        s2reg, wb, rd, wr;
  } ex_t;

  ex_t m_ex;
  int  m_cnt;

  function automatic ex_t bubble_f();
    ex_t e = '0;
    e.cmd = 4'd15;
    return e;
  endfunction

  function automatic ex_t id_f();
    ex_t e;
    e.valid = 1'b1;  e.cmd = id_exe_cmd;
    e.v1 = id_val1;  e.v2 = id_val2;  e.st = id_st_val;
    e.dest = id_dest; e.s1 = id_src1; e.s2 = id_src2;
    e.s2reg = id_src2_is_reg; e.wb = id_wb_en; e.rd = id_mem_rd; e.wr = id_mem_wr;
    return e;
  endfunction

  function automatic logic id_reads(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (r == id_src1) return 1'b1;
    return (id_src2_is_reg || id_mem_wr) && (r == id_src2);
  endfunction

  function automatic logic m_stall();
    if (rst || flush || !id_valid) return 1'b0;
    if (m_ex.valid && m_ex.rd && id_reads(m_ex.dest)) return 1'b1;
`ifndef ID_EX_FORWARDING_EN
    if (m_ex.wb && id_reads(m_ex.dest)) return 1'b1;
    if (mem_wb_en && id_reads(mem_dest)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] raw);
`ifdef ID_EX_FORWARDING_EN
    if (r != 5'd0 && mem_wb_en && mem_dest == r) return mem_result;
    if (r != 5'd0 && wb_wb_en && wb_dest == r) return wb_result;
`endif
    return raw;
  endfunction

  function automatic logic [31:0] exp_v1();
    return m_fwd(m_ex.s1, m_ex.v1);
  endfunction
  function automatic logic [31:0] exp_v2();
    return m_ex.s2reg ? m_fwd(m_ex.s2, m_ex.v2) : m_ex.v2;
  endfunction
  function automatic logic [31:0] exp_st();
    return m_ex.wr ? m_fwd(m_ex.s2, m_ex.st) : m_ex.st;
  endfunction

  task automatic tick();
    logic s;
    ex_t  nxt;
    s   = m_stall();
    nxt = (s || flush || !id_valid) ? bubble_f() : id_f();
    @(posedge clk);
    m_ex = nxt;
    if (s && m_cnt < 65535) m_cnt++;
  endtask

  task automatic idle();
    id_valid = 0; id_exe_cmd = 4'd15; id_val1 = 0; id_val2 = 0; id_st_val = 0;
    id_src1 = 0; id_src2 = 0; id_src2_is_reg = 0; id_dest = 0;
    id_wb_en = 0; id_mem_rd = 0; id_mem_wr = 0; flush = 0;
    mem_dest = 0; mem_wb_en = 0; mem_result = 0; wb_dest = 0; wb_wb_en = 0; wb_result = 0;
  endtask

  task automatic set_id(input logic [3:0] cmd, input logic [4:0] s1, input logic [4:0] s2,
                        input logic s2reg, input logic [4:0] dest, input logic [31:0] v1,
                        input logic [31:0] v2, input logic wb, input logic rd, input logic wr);
    id_valid = 1; id_exe_cmd = cmd; id_src1 = s1; id_src2 = s2; id_src2_is_reg = s2reg;
    id_dest = dest; id_val1 = v1; id_val2 = v2; id_st_val = 32'hC0DE_0000 | v1;
    id_wb_en = wb; id_mem_rd = rd; id_mem_wr = wr;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    id_valid = 1; id_src1 = 5'd1; mem_dest = 5'd1; mem_wb_en = 1;
    @(negedge clk); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (exe_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", exe_valid); end
    checks++; if (exe_cmd !== 4'd15) begin errors++; $display("FAIL reset_cmd: got %0d want 15", exe_cmd); end
    checks++; if ({val1, val2, st_val} !== 96'd0) begin errors++; $display("FAIL reset_operands: got %h %h %h want 0", val1, val2, st_val); end
    checks++; if ({exe_dest, exe_wb_en, exe_mem_rd, exe_mem_wr} !== 8'd0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", {exe_dest, exe_wb_en, exe_mem_rd, exe_mem_wr}); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    idle();
    rst = 0;
    m_ex = bubble_f();
    m_cnt = 0;
  endtask

  task automatic test_plain();
    @(negedge clk);
    set_id(4'd0, 5'd1, 5'd2, 1'b0, 5'd3, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL plain_stall: got %b want 0", stall); end
    tick();
    @(negedge clk); idle(); #1;
    checks++; if ({exe_valid, exe_cmd, exe_dest} !== {1'b1, 4'd0, 5'd3}) begin errors++; $display("FAIL plain_ctrl: got v=%b cmd=%0d dest=%0d want v=1 cmd=0 dest=3", exe_valid, exe_cmd, exe_dest); end
    checks++; if ({val1, val2} !== {32'd5, 32'd7}) begin errors++; $display("FAIL plain_vals: got %0d %0d want 5 7", val1, val2); end
    tick();
  endtask

  task automatic test_load_use();
    int c0;
    @(negedge clk);
    set_id(4'd0, 5'd1, 5'd0, 1'b0, 5'd4, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    set_id(4'd0, 5'd4, 5'd5, 1'b1, 5'd7, 32'hAA, 32'hBB, 1'b1, 1'b0, 1'b0);
    #1;
    c0 = m_cnt;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall: got %b want 1", stall); end
    tick();
    @(negedge clk); #1;
    checks++; if ({exe_valid, exe_cmd} !== {1'b0, 4'd15}) begin errors++; $display("FAIL loaduse_bubble: got v=%b cmd=%0d want v=0 cmd=15", exe_valid, exe_cmd); end
    checks++; if (stall_cnt !== 16'(c0 + 1)) begin errors++; $display("FAIL loaduse_cnt: got %0d want %0d", stall_cnt, c0 + 1); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL loaduse_release: got %b want 0", stall); end
    tick();
    @(negedge clk); idle(); #1;
    checks++; if ({exe_valid, exe_dest, val1} !== {1'b1, 5'd7, 32'hAA}) begin errors++; $display("FAIL loaduse_enter: got v=%b dest=%0d v1=%h want v=1 dest=7 v1=aa", exe_valid, exe_dest, val1); end
    tick();
  endtask

  task automatic test_flush();
    int c0;
    @(negedge clk);
    set_id(4'd0, 5'd1, 5'd0, 1'b0, 5'd4, 32'h1, 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    set_id(4'd1, 5'd4, 5'd4, 1'b1, 5'd8, 32'h2, 32'h3, 1'b1, 1'b0, 1'b0);
    flush = 1;
    #1;
    c0 = m_cnt;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall); end
    tick();
    @(negedge clk); idle(); #1;
    checks++; if ({exe_valid, exe_cmd, exe_dest, exe_wb_en} !== {1'b0, 4'd15, 5'd0, 1'b0}) begin errors++; $display("FAIL flush_bubble: got v=%b cmd=%0d dest=%0d want bubble", exe_valid, exe_cmd, exe_dest); end
    checks++; if (stall_cnt !== 16'(c0)) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt, c0); end
    tick();
  endtask

`ifdef ID_EX_FORWARDING_EN
  task automatic test_forward();
    @(negedge clk);
    set_id(4'd0, 5'd2, 5'd3, 1'b1, 5'd8, 32'h99, 32'h55, 1'b1, 1'b0, 1'b0);
    tick();
    @(negedge clk); idle();
    mem_dest = 5'd2; mem_wb_en = 1; mem_result = 32'h10;
    wb_dest = 5'd2; wb_wb_en = 1; wb_result = 32'h20;
    #1;
    checks++; if (val1 !== 32'h10) begin errors++; $display("FAIL fwd_mem: got %h want 10", val1); end
    checks++; if (val2 !== 32'h55) begin errors++; $display("FAIL fwd_v2_raw: got %h want 55", val2); end
    mem_wb_en = 0; #1;
    checks++; if (val1 !== 32'h20) begin errors++; $display("FAIL fwd_wb: got %h want 20", val1); end
    wb_wb_en = 0; #1;
    checks++; if (val1 !== 32'h99) begin errors++; $display("FAIL fwd_none: got %h want 99", val1); end
    tick();
    @(negedge clk);
    set_id(4'd0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h77, 32'h66, 1'b1, 1'b0, 1'b0);
    tick();
    @(negedge clk); idle();
    mem_dest = 5'd0; mem_wb_en = 1; mem_result = 32'h10;
    #1;
    checks++; if ({val1, val2} !== {32'h77, 32'h66}) begin errors++; $display("FAIL fwd_r0: got %h %h want 77 66", val1, val2); end
    idle();
    tick();
  endtask
`else
  task automatic test_no_forward();
    int c0;
    @(negedge clk);
    set_id(4'd0, 5'd1, 5'd0, 1'b0, 5'd6, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    set_id(4'd2, 5'd1, 5'd6, 1'b1, 5'd9, 32'h31, 32'h32, 1'b1, 1'b0, 1'b0);
    #1;
    c0 = m_cnt;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL nofwd_ex_stall: got %b want 1", stall); end
    tick();
    @(negedge clk);
    mem_dest = 5'd6; mem_wb_en = 1; mem_result = 32'hDEAD;
    #1;
    checks++; if ({stall, exe_valid} !== 2'b10) begin errors++; $display("FAIL nofwd_mem_stall: got stall=%b v=%b want 1 0", stall, exe_valid); end
    tick();
    @(negedge clk);
    mem_wb_en = 0; wb_dest = 5'd6; wb_wb_en = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nofwd_wb_nostall: got %b want 0", stall); end
    checks++; if (stall_cnt !== 16'(c0 + 2)) begin errors++; $display("FAIL nofwd_cnt: got %0d want %0d", stall_cnt, c0 + 2); end
    tick();
    @(negedge clk); idle(); #1;
    checks++; if ({exe_valid, exe_dest, val2} !== {1'b1, 5'd9, 32'h32}) begin errors++; $display("FAIL nofwd_enter: got v=%b dest=%0d v2=%h want 1 9 32", exe_valid, exe_dest, val2); end
    tick();
  endtask

  task automatic test_saturate();
    @(negedge clk); idle();
    id_valid = 1; id_src1 = 5'd3; id_dest = 5'd12; mem_dest = 5'd3; mem_wb_en = 1;
    for (int i = 0; i < 65600; i++) tick();
    @(negedge clk); #1;
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt: got %h want ffff", stall_cnt); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall: got %b want 1", stall); end
    idle();
    tick();
  endtask
`endif

  task automatic test_rst_mid_stall();
    @(negedge clk);
    set_id(4'd0, 5'd1, 5'd0, 1'b0, 5'd4, 32'h1, 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    set_id(4'd0, 5'd4, 5'd0, 1'b0, 5'd10, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if ({stall, exe_valid} !== 2'b11) begin errors++; $display("FAIL rstmid_pre: got stall=%b v=%b want 1 1", stall, exe_valid); end
    #2 rst = 1;
    #1;
    checks++; if ({stall, exe_valid, exe_cmd, exe_dest, exe_mem_rd} !== {1'b0, 1'b0, 4'd15, 5'd0, 1'b0}) begin errors++; $display("FAIL rstmid_async: got stall=%b v=%b cmd=%0d dest=%0d want 0 0 15 0", stall, exe_valid, exe_cmd, exe_dest); end
    checks++; if ({val1, stall_cnt} !== 48'd0) begin errors++; $display("FAIL rstmid_zero: got v1=%h cnt=%0d want 0 0", val1, stall_cnt); end
    m_ex = bubble_f();
    m_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    set_id(4'd5, 5'd1, 5'd0, 1'b0, 5'd11, 32'h55, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_release: got %b want 0", stall); end
    tick();
    @(negedge clk); idle(); #1;
    checks++; if ({exe_valid, exe_cmd, exe_dest, val1} !== {1'b1, 4'd5, 5'd11, 32'h55}) begin errors++; $display("FAIL rstmid_capture: got v=%b cmd=%0d dest=%0d v1=%h want 1 5 11 55", exe_valid, exe_cmd, exe_dest, val1); end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] cmds [11];
    cmds = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15};
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      id_valid = ($urandom_range(3) != 0);
      id_exe_cmd = cmds[$urandom_range(10)];
      id_val1 = $urandom; id_val2 = $urandom; id_st_val = $urandom;
      id_src1 = 5'($urandom_range(5)); id_src2 = 5'($urandom_range(5));
      id_src2_is_reg = 1'($urandom); id_dest = 5'($urandom_range(5));
      id_wb_en = 1'($urandom); id_mem_rd = ($urandom_range(2) == 0); id_mem_wr = ($urandom_range(3) == 0);
      flush = ($urandom_range(7) == 0);
      mem_dest = 5'($urandom_range(5)); mem_wb_en = ($urandom_range(3) == 0); mem_result = $urandom;
      wb_dest = 5'($urandom_range(5)); wb_wb_en = 1'($urandom); wb_result = $urandom;
      #1;
      checks++; if (stall !== m_stall()) begin errors++; $display("FAIL rand_stall[%0d]: got %b want %b", i, stall, m_stall()); end
      checks++; if ({exe_valid, exe_cmd, exe_dest, exe_wb_en, exe_mem_rd, exe_mem_wr} !== {m_ex.valid, m_ex.cmd, m_ex.dest, m_ex.wb, m_ex.rd, m_ex.wr}) begin errors++; $display("FAIL rand_ctrl[%0d]: got %h want %h", i, {exe_valid, exe_cmd, exe_dest, exe_wb_en, exe_mem_rd, exe_mem_wr}, {m_ex.valid, m_ex.cmd, m_ex.dest, m_ex.wb, m_ex.rd, m_ex.wr}); end
      checks++; if ({val1, val2, st_val} !== {exp_v1(), exp_v2(), exp_st()}) begin errors++; $display("FAIL rand_vals[%0d]: got %h %h %h want %h %h %h", i, val1, val2, st_val, exp_v1(), exp_v2(), exp_st()); end
      checks++; if (stall_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, stall_cnt, m_cnt); end
      tick();
    end
    @(negedge clk); idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_plain();
    test_load_use();
    test_flush();
`ifdef ID_EX_FORWARDING_EN
    test_forward();
`else
    test_no_forward();
`endif
    test_random();
`ifndef ID_EX_FORWARDING_EN
    test_saturate();
`endif
    test_rst_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
